// File: rtl/stage_d_pkg.sv
// Shared MIPS-I definitions for the decode stage: opcode/function/REGIMM codes,
// register-id width and the immediate sign-extension helper.
package stage_d_pkg;
  localparam int REG_W = 6;
  localparam logic [REG_W-1:0] REG_ZERO = 6'd0;
  localparam logic [REG_W-1:0] REG_RA   = 6'd31;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2A;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_SWR     = 6'h2E;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_ADDU    = 6'h21;

  localparam logic [4:0] RI_BLTZ    = 5'h00;
  localparam logic [4:0] RI_BGEZ    = 5'h01;
  localparam logic [4:0] RI_BLTZAL  = 5'h10;
  localparam logic [4:0] RI_BGEZAL  = 5'h11;

  function automatic logic signed [31:0] sext16(input logic [15:0] v);
    return $signed({{16{v[15]}}, v});
  endfunction
endpackage

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file: one synchronous write port, two
// combinational read ports; register 0 always reads zero.
module mips_regfile (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] mem_q [32];

  // Contents are deliberately not reset; entry 0 is never written.
  always_ff @(posedge clk) begin
    if (we_i && (wa_i != 5'd0)) mem_q[wa_i] <= wd_i;
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : mem_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : mem_q[ra2_i];
endmodule

// File: rtl/stage_d.sv
// MIPS-I decode stage: field decode, register read with X/M forwarding,
// immediate/target generation, D-stage registers and RAW hazard detection.
module stage_d
  import stage_d_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             i_valid,
  input  logic [31:0]      i_instr,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_npc,
  input  logic [REG_W-1:0] x_wbr,
  input  logic [31:0]      x_res,
  input  logic [REG_W-1:0] m_wbr,
  input  logic [31:0]      m_res,
  output logic             d_valid,
  output logic [31:0]      d_instr,
  output logic [31:0]      d_pc,
  output logic [31:0]      d_npc,
  output logic [5:0]       d_opcode,
  output logic [5:0]       d_fn,
  output logic [4:0]       d_rd,
  output logic [REG_W-1:0] d_rs,
  output logic [REG_W-1:0] d_rt,
  output logic [4:0]       d_sa,
  output logic [31:0]      d_op1_val,
  output logic [31:0]      d_op2_val,
  output logic [31:0]      d_rt_val,
  output logic [REG_W-1:0] d_wbr,
  output logic [31:0]      d_target,
  output logic             d_hazzard
);
  logic [5:0]       opcode;
  logic [REG_W-1:0] rs, rt;
  logic [15:0]      imm;
  logic [31:0]      rf_rs, rf_rt, rs_val, rt_val;
  logic [31:0]      op2_val, target;
  logic [REG_W-1:0] wbr_dec;
  logic             reads_rt, rf_we;
  logic signed [31:0] br_off;

  logic             valid_d, valid_q;
  logic [REG_W-1:0] wbr_d, wbr_q;
  logic [31:0]      instr_q, pc_q, npc_q, op1_q, op2_q, rtv_q, tgt_q;

  assign opcode = i_instr[31:26];
  assign rs     = {1'b0, i_instr[25:21]};
  assign rt     = {1'b0, i_instr[20:16]};
  assign imm    = i_instr[15:0];
  assign rf_we  = (m_wbr[5] == 1'b0) && (m_wbr[4:0] != 5'd0);

  mips_regfile u_rf (
    .clk   (clk),
    .we_i  (rf_we),
    .wa_i  (m_wbr[4:0]),
    .wd_i  (m_res),
    .ra1_i (rs[4:0]),
    .ra2_i (rt[4:0]),
    .rd1_o (rf_rs),
    .rd2_o (rf_rt)
  );

  // X is younger than M, so its result wins when both target the same register.
  function automatic logic [31:0] fwd(input logic [REG_W-1:0] r, input logic [31:0] rf_v,
                                      input logic [REG_W-1:0] xw, input logic [31:0] xr,
                                      input logic [REG_W-1:0] mw, input logic [31:0] mr);
    if (r == REG_ZERO) return 32'd0;
    if (xw == r)       return xr;
    if (mw == r)       return mr;
    return rf_v;
  endfunction

  assign rs_val = fwd(rs, rf_rs, x_wbr, x_res, m_wbr, m_res);
  assign rt_val = fwd(rt, rf_rt, x_wbr, x_res, m_wbr, m_res);
  assign br_off = sext16(imm) <<< 2;

  always_comb begin
    op2_val = $unsigned(sext16(imm));
    wbr_dec = REG_ZERO;
    target  = i_npc + $unsigned(br_off);
    if (opcode == OP_J || opcode == OP_JAL) target = {i_npc[31:28], i_instr[25:0], 2'b00};
    if (opcode <= OP_BGTZ && opcode != OP_J && opcode != OP_JAL) op2_val = rt_val;
    else if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI) op2_val = {16'd0, imm};
    else if (opcode == OP_LUI) op2_val = {imm, 16'd0};
    if (opcode == OP_SPECIAL) wbr_dec = {1'b0, i_instr[15:11]};
    else if (opcode == OP_JAL) wbr_dec = REG_RA;
    else if (opcode == OP_REGIMM && (rt[4:0] == RI_BLTZAL || rt[4:0] == RI_BGEZAL)) wbr_dec = REG_RA;
    else if ((opcode >= OP_ADDI && opcode <= OP_LUI) || (opcode >= OP_LB && opcode <= OP_LWR))
      wbr_dec = rt;
  end

  assign reads_rt = (opcode == OP_SPECIAL) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                    (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW) ||
                    (opcode == OP_SWL) || (opcode == OP_SWR);

  assign valid_d = i_valid && !flush;
  assign wbr_d   = valid_d ? wbr_dec : REG_ZERO;

  // D-stage register boundary: stall holds everything, flush only kills valid/wbr.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      wbr_q   <= REG_ZERO;
      instr_q <= '0;
      pc_q    <= '0;
      npc_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      rtv_q   <= '0;
      tgt_q   <= '0;
    end else if (!stall) begin
      valid_q <= valid_d;
      wbr_q   <= wbr_d;
      instr_q <= i_instr;
      pc_q    <= i_pc;
      npc_q   <= i_npc;
      op1_q   <= rs_val;
      op2_q   <= op2_val;
      rtv_q   <= rt_val;
      tgt_q   <= target;
    end
  end

  assign d_valid   = valid_q;
  assign d_instr   = instr_q;
  assign d_pc      = pc_q;
  assign d_npc     = npc_q;
  assign d_opcode  = instr_q[31:26];
  assign d_fn      = instr_q[5:0];
  assign d_rd      = instr_q[15:11];
  assign d_rs      = {1'b0, instr_q[25:21]};
  assign d_rt      = {1'b0, instr_q[20:16]};
  assign d_sa      = instr_q[10:6];
  assign d_op1_val = op1_q;
  assign d_op2_val = op2_q;
  assign d_rt_val  = rtv_q;
  assign d_wbr     = wbr_q;
  assign d_target  = tgt_q;

  // The instruction in D has not produced its result yet, so no forwarding path covers it.
  assign d_hazzard = i_valid && valid_q && (wbr_q != REG_ZERO) &&
                     ((wbr_q == rs) || (reads_rt && (wbr_q == rt)));
endmodule

// File: tb/tb_stage_d.sv
// Bench for stage_d: directed cases with literal expectations plus randomized
// traffic compared every cycle against a behavioural model of the decode stage.
module tb_stage_d;
  logic        clk = 1'b0;
  logic        rst, stall, flush, i_valid;
  logic [31:0] i_instr, i_pc, i_npc, x_res, m_res;
  logic [5:0]  x_wbr, m_wbr;
  logic        d_valid, d_hazzard;
  logic [31:0] d_instr, d_pc, d_npc, d_op1_val, d_op2_val, d_rt_val, d_target;
  logic [5:0]  d_opcode, d_fn, d_rs, d_rt, d_wbr;
  logic [4:0]  d_rd, d_sa;

  stage_d dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .i_valid(i_valid),
    .i_instr(i_instr), .i_pc(i_pc), .i_npc(i_npc), .x_wbr(x_wbr), .x_res(x_res),
    .m_wbr(m_wbr), .m_res(m_res), .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc),
    .d_npc(d_npc), .d_opcode(d_opcode), .d_fn(d_fn), .d_rd(d_rd), .d_rs(d_rs),
    .d_rt(d_rt), .d_sa(d_sa), .d_op1_val(d_op1_val), .d_op2_val(d_op2_val),
    .d_rt_val(d_rt_val), .d_wbr(d_wbr), .d_target(d_target), .d_hazzard(d_hazzard)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Model state: architectural registers and the expected D-stage contents.
  logic [31:0] mrf [32];
  logic        e_valid = 1'b0;
  logic [5:0]  e_wbr = '0;
  logic [31:0] e_instr = '0, e_pc = '0, e_npc = '0, e_op1 = '0, e_op2 = '0, e_rtv = '0, e_tgt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int s, input int t, input int d, input int f);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'(f)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int s, input int t, input int im);
    return {6'(op), 5'(s), 5'(t), 16'(im)};
  endfunction

  function automatic logic [31:0] reg_value(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (x_wbr == {1'b0, r}) return x_res;
    if (m_wbr == {1'b0, r}) return m_res;
    return mrf[r];
  endfunction

  function automatic bit stores_or_compares(input logic [5:0] op);
    return op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h28 || op == 6'h29 ||
           op == 6'h2A || op == 6'h2B || op == 6'h2E;
  endfunction

  function automatic bit exp_hazard();
    logic [5:0] s, t;
    s = {1'b0, i_instr[25:21]};
    t = {1'b0, i_instr[20:16]};
    return i_valid && e_valid && e_wbr != 0 &&
           (e_wbr == s || (stores_or_compares(i_instr[31:26]) && e_wbr == t));
  endfunction

  task automatic compare_all();
    chk("d_valid", 32'(d_valid), 32'(e_valid));
    chk("d_instr", d_instr, e_instr);
    chk("d_pc", d_pc, e_pc);
    chk("d_npc", d_npc, e_npc);
    chk("d_opcode", 32'(d_opcode), 32'(e_instr[31:26]));
    chk("d_fn", 32'(d_fn), 32'(e_instr[5:0]));
    chk("d_rd", 32'(d_rd), 32'(e_instr[15:11]));
    chk("d_rs", 32'(d_rs), 32'(e_instr[25:21]));
    chk("d_rt", 32'(d_rt), 32'(e_instr[20:16]));
    chk("d_sa", 32'(d_sa), 32'(e_instr[10:6]));
    chk("d_op1_val", d_op1_val, e_op1);
    chk("d_op2_val", d_op2_val, e_op2);
    chk("d_rt_val", d_rt_val, e_rtv);
    chk("d_wbr", 32'(d_wbr), 32'(e_wbr));
    chk("d_target", d_target, e_tgt);
    chk("d_hazzard", 32'(d_hazzard), 32'(exp_hazard()));
  endtask

  // Expected D-stage contents one cycle later, computed from the current inputs.
  task automatic model_step();
    logic [5:0]  op;
    logic [15:0] im;
    int          simm;
    logic [31:0] rtv, op2, tgt;
    logic [5:0]  wb;
    op   = i_instr[31:26];
    im   = i_instr[15:0];
    simm = int'($signed(im));
    rtv  = reg_value(i_instr[20:16]);
    op2  = 32'(simm);
    wb   = 6'd0;
    if (op == 0 || op == 1 || (op >= 4 && op <= 7)) op2 = rtv;
    else if (op >= 12 && op <= 14) op2 = 32'(im);
    else if (op == 15) op2 = 32'(im) * 32'h10000;
    if (op == 0) wb = {1'b0, i_instr[15:11]};
    else if (op == 3) wb = 6'd31;
    else if (op == 1 && (i_instr[20:16] == 5'h10 || i_instr[20:16] == 5'h11)) wb = 6'd31;
    else if ((op >= 8 && op <= 15) || (op >= 6'h20 && op <= 6'h26)) wb = {1'b0, i_instr[20:16]};
    if (op == 2 || op == 3) tgt = {i_npc[31:28], i_instr[25:0], 2'b00};
    else tgt = i_npc + 32'(4 * simm);
    if (rst) begin
      e_valid = 0; e_wbr = 0; e_instr = 0; e_pc = 0; e_npc = 0;
      e_op1 = 0; e_op2 = 0; e_rtv = 0; e_tgt = 0;
    end else if (!stall) begin
      e_valid = i_valid && !flush;
      e_wbr   = e_valid ? wb : 6'd0;
      e_instr = i_instr; e_pc = i_pc; e_npc = i_npc;
      e_op1   = reg_value(i_instr[25:21]);
      e_op2   = op2; e_rtv = rtv; e_tgt = tgt;
    end
    if (m_wbr >= 1 && m_wbr <= 31) mrf[m_wbr[4:0]] = m_res;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    i_valid = 1'b1;
    i_instr = ins;
    tick();
  endtask

  logic [31:0] held, r;
  logic [5:0]  ops [24] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                            6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                            6'h0F, 6'h20, 6'h23, 6'h26, 6'h28, 6'h2B, 6'h2E, 6'h3F};

  initial begin
    rst = 1; stall = 0; flush = 0; i_valid = 0; i_instr = 0;
    i_pc = 0; i_npc = 4; x_wbr = 0; x_res = 0; m_wbr = 0; m_res = 0;
    foreach (mrf[k]) mrf[k] = 32'd0;
    tick(); tick();
    chk("reset_valid", 32'(d_valid), 32'd0);
    chk("reset_target", d_target, 32'd0);
    rst = 0;
    for (int k = 1; k < 32; k++) begin
      m_wbr = 6'(k); m_res = $urandom;
      tick();
    end
    m_wbr = 0;

    x_wbr = 5; x_res = 32'h1234; m_wbr = 5; m_res = 32'h9999;
    issue(rtype(5, 0, 3, 6'h21));
    chk("fwd_x_op1", d_op1_val, 32'h1234);
    chk("fwd_x_wbr", 32'(d_wbr), 32'd3);
    chk("fwd_x_valid", 32'(d_valid), 32'd1);
    x_wbr = 0; m_wbr = 7; m_res = 32'hDEADBEEF; i_valid = 0;
    tick();
    m_wbr = 0; m_res = 32'h5555;
    issue(itype(6'h2B, 0, 7, 4));
    chk("rf_rt_val", d_rt_val, 32'hDEADBEEF);
    chk("rf_sw_op2", d_op2_val, 32'd4);
    chk("rf_sw_wbr", 32'(d_wbr), 32'd0);

    issue(itype(6'h23, 1, 2, 0));
    i_instr = rtype(2, 2, 4, 6'h21); #1;
    chk("raw_hazard", 32'(d_hazzard), 32'd1);
    i_instr = rtype(1, 1, 4, 6'h21); #1;
    chk("raw_nohazard", 32'(d_hazzard), 32'd0);
    tick();

    issue(itype(6'h0D, 0, 1, 16'h8000));
    chk("ori_zext", d_op2_val, 32'h00008000);
    issue(itype(6'h08, 0, 1, 16'h8000));
    chk("addi_sext", d_op2_val, 32'hFFFF8000);
    i_pc = 32'hFC; i_npc = 32'h100;
    issue(itype(6'h04, 0, 0, 16'hFFFF));
    chk("beq_target", d_target, 32'hFC);

    held = rtype(5, 6, 9, 6'h21);
    issue(held);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      i_pc = $urandom; i_npc = $urandom; i_valid = k[0];
      issue($urandom);
      chk("stall_instr", d_instr, held);
      chk("stall_wbr", 32'(d_wbr), 32'd9);
    end
    stall = 0; flush = 1;
    issue(rtype(1, 2, 3, 6'h21));
    chk("flush_valid", 32'(d_valid), 32'd0);
    chk("flush_wbr", 32'(d_wbr), 32'd0);
    flush = 0;

    x_wbr = 0; m_wbr = 0; x_res = 32'hAAAA; m_res = 32'hBBBB;
    issue(rtype(0, 0, 1, 6'h21));
    chk("r0_op1", d_op1_val, 32'd0);
    chk("r0_rtval", d_rt_val, 32'd0);
    issue(rtype(1, 2, 3, 6'h21));

    rst = 1;
    issue(rtype(4, 5, 6, 6'h21));
    chk("rst_valid", 32'(d_valid), 32'd0);
    chk("rst_instr", d_instr, 32'd0);
    chk("rst_wbr", 32'(d_wbr), 32'd0);
    rst = 0;

    for (int n = 0; n < 800; n++) begin
      r = $urandom;
      i_instr = {ops[$urandom_range(0, 23)], r[25:0]};
      if (i_instr[31:26] != 6'h02 && i_instr[31:26] != 6'h03) begin
        i_instr[25:21] = 5'($urandom_range(0, 7));
        i_instr[20:16] = ($urandom_range(0, 3) == 0) ? 5'(16 + $urandom_range(0, 1))
                                                     : 5'($urandom_range(0, 7));
      end
      i_valid = ($urandom_range(0, 4) != 0);
      stall   = ($urandom_range(0, 9) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      rst     = ($urandom_range(0, 49) == 0);
      i_pc    = $urandom; i_npc = $urandom;
      x_wbr   = ($urandom_range(0, 9) == 0) ? 6'd40 : 6'($urandom_range(0, 8));
      m_wbr   = ($urandom_range(0, 9) == 0) ? 6'd39 : 6'($urandom_range(0, 8));
      x_res   = $urandom; m_res = $urandom;
      tick();
    end
    rst = 0; stall = 0; flush = 0; i_valid = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/stage_d.md
Name: stage_d

Overview:
- MIPS-I decode stage of the five-stage mipscore pipeline (I, D, X, M, W).
- Takes the fetched instruction from the I stage and decodes its fields.
- Reads the 32x32 register file, forwarding results from the X and M stages.
- Registers operands, immediates, branch target and writeback register for the X stage, and flags read-after-write hazards to the pipeline controller. It also owns the register file, which is written from the M stage outputs.

Parameters:
- none

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold all registered outputs
- flush  in  1  insert bubble: next d_valid=0, d_wbr=0
- i_valid  in  1  i_instr is a real instruction
- i_instr  in  32  instruction to decode
- i_pc  in  32  its PC
- i_npc  in  32  its PC+4 (delay-slot address)
- x_wbr  in  6  dest reg of instruction leaving X (0 = none)
- x_res  in  32  its result
- m_wbr  in  6  dest reg of instruction leaving M (0 = none); also register-file write port
- m_res  in  32  its result / write data
- d_valid  out  1  outputs hold a real instruction
- d_instr, d_pc, d_npc  out  32 each  registered copies of i_instr, i_pc, i_npc
- d_opcode  out  6  instr[31:26]
- d_fn  out  6  instr[5:0]
- d_rd  out  5  instr[15:11]
- d_rs  out  6  {0, instr[25:21]}
- d_rt  out  6  {0, instr[20:16]}
- d_sa  out  5  instr[10:6]
- d_op1_val  out  32  forwarded rs value
- d_op2_val  out  32  second operand (rt value or extended immediate)
- d_rt_val  out  32  forwarded rt value (store data / compare)
- d_wbr  out  6  destination register, 0 = no write
- d_target  out  32  branch/jump target
- d_hazzard  out  1  combinational RAW hazard on the current input

Behaviour:
- Register encoding:
  - 6-bit register ids; 1..31 are GPRs; 32..63 are reserved and never written by this block.
  - Register 0 always reads 0.
- Register file:
  - On each posedge, m_res is written to entry m_wbr[4:0] when m_wbr is in 1..31.
  - Contents are not reset.
- Operand forwarding (combinational, per source r = rs or rt):
  - r == 0: value 0.
  - else if x_wbr == r: x_res.
  - else if m_wbr == r: m_res.
  - else the register-file value.
- d_op2_val:
  - SPECIAL, REGIMM, BEQ, BNE, BLEZ, BGTZ: rt value.
  - ANDI/ORI/XORI: zero-extended imm16.
  - LUI: imm16<<16.
  - All other opcodes: sign-extended imm16.
- d_wbr:
  - SPECIAL: rd.
  - JAL: 31.
  - REGIMM BLTZAL/BGEZAL: 31.
  - ADDI..LUI and loads: rt.
  - Branches, J, stores, undefined opcodes: 0.
  - A result of 0 stays 0.
- d_target:
  - J/JAL: {i_npc[31:28], instr[25:0], 2'b00}.
  - Otherwise: i_npc + (sext(imm16)<<2), with 32-bit wrap-around.
  - JR/JALR targets come from d_op1_val in X, not from d_target.
- Register update on posedge:
  - rst: all outputs 0.
  - else stall: hold every output unchanged. Stall has priority over flush.
  - else flush: load the fields normally, but force d_valid=0 and d_wbr=0.
  - else: load the decoded fields; d_valid=i_valid; d_wbr is forced to 0 when i_valid=0.
- Latency: one cycle from i_* to d_*.
- d_hazzard is asserted when all of the following hold:
  - i_valid and d_valid are both 1;
  - d_wbr != 0 (its result is not yet available in x_res);
  - d_wbr == rs, or d_wbr == rt and the instruction reads rt.
- Instructions that read rt: SPECIAL, BEQ, BNE, SB, SH, SW, SWL, SWR.
- d_hazzard is evaluated independently of stall and flush. The controller responds by flushing D and stalling I.

Decomposition:
- Shared package (mips_asm defs): opcode, fn and REGIMM constants; the 6-bit register-id width; the zero-register constant.
- One natural sub-module: mips_regfile. It is 32x32 with one write port and two combinational read ports, and register 0 reads 0.
- Decode, forwarding and hazard logic stay in stage_d.

Test Plan:
- Forward from X:
  - Stimulus: x_wbr=5, x_res=0x1234, m_wbr=5, m_res=0x9999; decode ADDU r3,r5,r0.
  - Required next cycle: d_op1_val=0x1234, d_wbr=3, d_valid=1.
- Write and read register file:
  - Stimulus: m_wbr=7, m_res=0xDEADBEEF for one cycle, then m_wbr=0; decode SW r7,4(r0).
  - Required: d_rt_val=0xDEADBEEF, d_op2_val=4, d_wbr=0.
- RAW hazard:
  - Stimulus: issue LW r2,0(r1), then present ADDU r4,r2,r2 with i_valid=1.
  - Required: d_hazzard=1 in that cycle.
  - Stimulus: same case with r1 as the dependent register instead.
  - Required: d_hazzard=0.
- Immediates and target:
  - Stimulus: ORI r1,r0,0x8000.
  - Required: d_op2_val=0x00008000.
  - Stimulus: ADDI with imm 0x8000.
  - Required: d_op2_val=0xFFFF8000.
  - Stimulus: BEQ at i_npc=0x100 with imm 0xFFFF.
  - Required: d_target=0xFC.
- Stall, flush, reset:
  - Stimulus: stall=1 for 3 cycles while i_* changes.
  - Required: all d_* constant.
  - Stimulus: flush=1.
  - Required: d_valid=0, d_wbr=0.
  - Stimulus: rst=1.
  - Required: all outputs 0 next cycle.
- Register 0:
  - Stimulus: m_wbr=0, x_wbr=0 with nonzero results; decode ADDU r1,r0,r0.
  - Required: d_op1_val=0, d_rt_val=0; the register file is unchanged.
